mem_port_arbiter: RTL and testbench

- Sits directly downstream of the pipelined RV32I datapath.
- Merges the datapath's instruction-fetch port and data (load/store) port onto a single shared word-wide memory port.
- Serialises requests with a registered FSM: data has priority, and a starvation counter guarantees that instruction fetch makes forward progress.
- Each upstream requester holds its request until it receives a one-cycle response pulse.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the RV32I datapath ports, the arbiter and the shared memory port.
interface mem_port_arbiter_if;
  // Instruction-fetch port
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;

  // Data (load/store) port
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;

  // Shared memory port
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    input  mem_resp, mem_rdata,
    output inst_resp, inst_rdata,
    output data_resp, data_rdata,
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

  // Environment view: upstream requesters plus the memory
  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    output mem_resp, mem_rdata,
    input  inst_resp, inst_rdata,
    input  data_resp, data_rdata,
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges instruction-fetch and data ports onto one word-wide memory port.
// Data has priority; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while a fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             i_req;
  logic             grant_i;
  logic             grant_d;

  // Arbitration terms, only acted upon while IDLE
  assign d_req   = bus.data_read | bus.data_write;
  assign i_req   = bus.inst_read;
  assign grant_i = i_req & (~d_req | (starve_cnt >= LIMIT));
  assign grant_d = d_req & ~grant_i;

  // Completion pulses are gated by the port currently being served
  assign bus.inst_resp  = (state == SERVE_I) & bus.mem_resp;
  assign bus.data_resp  = (state == SERVE_D) & bus.mem_resp;
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;

  // Arbiter FSM: grant capture, hold until mem_resp, starvation tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_mbe   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.inst_read) begin
            starve_cnt <= '0;
          end
          if (grant_i) begin
            state         <= SERVE_I;
            bus.mem_read  <= 1'b1;
            bus.mem_write <= 1'b0;
            bus.mem_mbe   <= 4'b1111;
            bus.mem_addr  <= bus.inst_addr;
            bus.mem_wdata <= '0;
          end else if (grant_d) begin
            // A store wins when both read and write are requested
            state         <= SERVE_D;
            bus.mem_read  <= bus.data_read & ~bus.data_write;
            bus.mem_write <= bus.data_write;
            bus.mem_mbe   <= bus.data_mbe;
            bus.mem_addr  <= bus.data_addr;
            bus.mem_wdata <= bus.data_wdata;
          end
        end
        SERVE_I: begin
          if (bus.mem_resp) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            starve_cnt    <= '0;
          end
        end
        SERVE_D: begin
          if (bus.mem_resp) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (bus.inst_read && (starve_cnt < LIMIT)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a latency-configurable
// memory model, and a monitor comparing grants/responses against queued expectations.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  mbe;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wiggle;
  } op_t;

  typedef struct {
    bit          is_data;
    logic        rd;
    logic        wr;
    logic [3:0]  mbe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  op_t  i_q[$];
  op_t  d_q[$];
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h60) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h cycle=%0d", name, got, want, cyc);
    end
  endtask

  task automatic push_inst(input logic [31:0] a, input bit wig, input int lat);
    op_t  o;
    exp_t e;
    o.rd = 1'b1; o.wr = 1'b0; o.mbe = 4'hF; o.addr = a; o.wdata = 32'h0; o.wiggle = wig;
    i_q.push_back(o);
    e.is_data = 1'b0; e.rd = 1'b1; e.wr = 1'b0; e.mbe = 4'hF; e.addr = a;
    e.wdata = 32'h0; e.rdata = mem_data(a); e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic push_data(input logic rd, input logic wr, input logic [3:0] mbe,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input bit with_exp);
    op_t  o;
    exp_t e;
    o.rd = rd; o.wr = wr; o.mbe = mbe; o.addr = a; o.wdata = wd; o.wiggle = 1'b0;
    d_q.push_back(o);
    if (with_exp) begin
      e.is_data = 1'b1; e.rd = rd & ~wr; e.wr = wr; e.mbe = mbe; e.addr = a;
      e.wdata = wd; e.rdata = mem_data(a); e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  // Instruction requester: holds request until inst_resp, optionally perturbs address while served
  op_t i_op;
  bit  i_busy = 1'b0;
  bit  i_done = 1'b0;
  int  i_req_cyc = 0;
  initial begin
    bus.inst_read = 1'b0;
    bus.inst_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (i_busy && i_done) begin
        i_busy = 1'b0;
        bus.inst_read = 1'b0;
      end
      if (i_busy && i_op.wiggle) bus.inst_addr = bus.inst_addr + 32'h1000;
      if (!i_busy && i_q.size() > 0) begin
        i_op = i_q.pop_front();
        bus.inst_addr = i_op.addr;
        bus.inst_read = 1'b1;
        i_busy = 1'b1;
        i_req_cyc = cyc;
      end
      i_done = 1'b0;
      @(negedge clk);
      if (i_busy && bus.inst_resp) i_done = 1'b1;
    end
  end

  // Data requester: holds request until data_resp; abort drops everything
  op_t d_op;
  bit  d_busy = 1'b0;
  bit  d_done = 1'b0;
  bit  d_abort = 1'b0;
  int  d_req_cyc = 0;
  initial begin
    bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_mbe = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (d_abort) begin
        bus.data_read = 1'b0; bus.data_write = 1'b0;
        d_busy = 1'b0;
      end else begin
        if (d_busy && d_done) begin
          d_busy = 1'b0;
          bus.data_read = 1'b0; bus.data_write = 1'b0;
        end
        if (!d_busy && d_q.size() > 0) begin
          d_op = d_q.pop_front();
          bus.data_read = d_op.rd; bus.data_write = d_op.wr; bus.data_mbe = d_op.mbe;
          bus.data_addr = d_op.addr; bus.data_wdata = d_op.wdata;
          d_busy = 1'b1;
          d_req_cyc = cyc;
        end
      end
      d_done = 1'b0;
      @(negedge clk);
      if (d_busy && bus.data_resp) d_done = 1'b1;
    end
  end

  // Memory: responds mem_lat cycles after first seeing a strobe, even if the strobe vanished
  int          mem_lat = 1;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr;
  initial begin
    bus.mem_resp = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
      if (!m_pend && (bus.mem_read || bus.mem_write)) begin
        m_pend = 1'b1; m_cnt = 0; m_addr = bus.mem_addr;
      end
      if (m_pend) begin
        m_cnt++;
        if (m_cnt >= mem_lat) begin
          bus.mem_resp = 1'b1;
          bus.mem_rdata = mem_data(m_addr);
          m_pend = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectation at each new grant, checks hold and the response pulse
  exp_t cur;
  bit   mon_en = 1'b0;
  bit   active = 1'b0;
  bit   post = 1'b0;
  int   timer = 0;
  always @(negedge clk) begin
    bit responded;
    responded = 1'b0;
    if (!mon_en) begin
      active = 1'b0; post = 1'b0; timer = 0;
    end else begin
      if (post) begin
        chk("strobe_clear", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        post = 1'b0;
      end else if (!active && (bus.mem_read || bus.mem_write)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_grant: got addr=0x%08h expected no grant cycle=%0d", bus.mem_addr, cyc);
          cur.is_data = 1'b0; cur.rd = bus.mem_read; cur.wr = bus.mem_write; cur.mbe = bus.mem_mbe;
          cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata; cur.rdata = 32'h0; cur.lat = -1;
        end else begin
          cur = exp_q.pop_front();
          chk("grant_strobes", 32'({bus.mem_read, bus.mem_write}), 32'({cur.rd, cur.wr}));
          chk("grant_addr", bus.mem_addr, cur.addr);
          chk("grant_mbe", 32'(bus.mem_mbe), 32'(cur.mbe));
          chk("grant_wdata", bus.mem_wdata, cur.wdata);
          if (cur.lat >= 0)
            chk("grant_latency", 32'(cyc - (cur.is_data ? d_req_cyc : i_req_cyc)), 32'(cur.lat));
        end
        active = 1'b1; timer = 0;
      end
      if (active) begin
        chk("hold_addr", bus.mem_addr, cur.addr);
        chk("hold_ctrl", 32'({bus.mem_read, bus.mem_write, bus.mem_mbe}), 32'({cur.rd, cur.wr, cur.mbe}));
        chk("hold_wdata", bus.mem_wdata, cur.wdata);
        if (bus.inst_resp || bus.data_resp) begin
          chk("resp_port", 32'({bus.inst_resp, bus.data_resp}), cur.is_data ? 32'd1 : 32'd2);
          chk("resp_rdata", cur.is_data ? bus.data_rdata : bus.inst_rdata, cur.rdata);
          active = 1'b0; post = 1'b1; responded = 1'b1;
        end else begin
          timer++;
          if (timer > 40) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: got no response after %0d cycles expected one cycle=%0d", timer, cyc);
            active = 1'b0;
          end
        end
      end
      if (!active && !responded)
        chk("idle_resp", 32'({bus.inst_resp, bus.data_resp}), 32'd0);
    end
  end

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || i_busy || d_busy || i_q.size() != 0 || d_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_complete"}, 32'(n < limit), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_late;
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_read", 32'(bus.mem_read), 32'd0);
    chk("reset_mem_write", 32'(bus.mem_write), 32'd0);
    chk("reset_mem_mbe", 32'(bus.mem_mbe), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset_inst_resp", 32'(bus.inst_resp), 32'd0);
    chk("reset_data_resp", 32'(bus.data_resp), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single fetch, 3-cycle memory
    mem_lat = 3;
    push_inst(32'h60, 1'b0, 1);
    wait_idle("single_fetch", 100);

    // Simultaneous requests: data first, then fetch
    mem_lat = 1;
    push_data(1'b0, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 1, 1'b1);
    push_inst(32'h64, 1'b0, -1);
    wait_idle("simultaneous", 100);

    // Read and write together: the write wins
    mem_lat = 2;
    push_data(1'b1, 1'b1, 4'hF, 32'h140, 32'h12345678, 1, 1'b1);
    wait_idle("read_write", 100);

    // Plain load, byte enables and write data still forwarded
    push_data(1'b1, 1'b0, 4'h0, 32'h180, 32'hCAFEF00D, 1, 1'b1);
    wait_idle("load", 100);

    // Starvation: 4 data grants, fetch, counter cleared so 2 more data, then fetch
    mem_lat = 1;
    for (int k = 0; k < 4; k++) push_data(1'b1, 1'b0, 4'hF, 32'h300 + 32'(4 * k), 32'h0, -1, 1'b1);
    push_inst(32'h80, 1'b0, -1);
    push_data(1'b1, 1'b0, 4'hF, 32'h310, 32'h0, -1, 1'b1);
    push_data(1'b1, 1'b0, 4'hF, 32'h314, 32'h0, -1, 1'b1);
    push_inst(32'h84, 1'b0, -1);
    wait_idle("starvation", 300);

    // Fetch address changes while being served; latched address must hold
    mem_lat = 4;
    push_inst(32'hA0, 1'b1, 1);
    wait_idle("hold_stable", 100);

    // Reset during a data transaction; the late memory response must be ignored
    mon_en = 1'b0;
    mem_lat = 8;
    push_data(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, -1, 1'b0);
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_grant", 32'(bus.mem_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    d_abort = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    saw_late = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_late |= bus.mem_resp;
      chk("rst_resp_quiet", 32'({bus.inst_resp, bus.data_resp}), 32'd0);
      chk("rst_mem_ctrl", 32'({bus.mem_read, bus.mem_write, bus.mem_mbe}), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    end
    chk("rst_late_resp_seen", 32'(saw_late), 32'd1);
    d_abort = 1'b0;
    mon_en = 1'b1;

    // Normal operation resumes from IDLE after the aborted transaction
    mem_lat = 1;
    push_inst(32'hC0, 1'b0, 1);
    wait_idle("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
